operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 The module SHALL have parameter WIDTH, default `FP_WIDTH, meaning bit width of one signed fixed-point element.
REQ-002 The module SHALL have parameter N, default 4, meaning vector dimensionality (lanes per output vector, N >= 2).
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 The module SHALL have port in_valid, input, 1, meaning the upstream element pair is valid.
REQ-006 The module SHALL have port in_ready, output, 1, meaning the loader accepts an element this cycle.
REQ-007 The module SHALL have ports in_a and in_b, input, signed WIDTH each, meaning the element pair for the current lane.
REQ-008 The module SHALL have port in_last, input, 1, meaning the element closes the vector early (used only under REQ-026).
REQ-009 The module SHALL have port out_valid, output, 1, meaning a complete vector pair is presented.
REQ-010 The module SHALL have port out_ready, input, 1, meaning the downstream dot-product stage consumes the vector.
REQ-011 The module SHALL have ports out_a[N] and out_b[N], output, signed WIDTH each, meaning the parallel operand vectors for the dot-product stage.

Function
REQ-012 Accept on in_valid && in_ready; drain on out_valid && out_ready.
REQ-013 Two vector banks (ping-pong); each bank holds N a-elements, N b-elements and a full flag.
REQ-014 Fill FSM states: FILL (writing lane idx of bank wr_bank) and STALL (bank wr_bank full). FILL->STALL when a vector completes and the other bank is full; STALL->FILL when that bank drains.
REQ-015 in_ready = 1 in FILL, 0 in STALL; combinational from registered state only.
REQ-016 An accepted element SHALL be written to lane idx; idx increments by 1; lane order is arrival order.
REQ-017 On acceptance with idx == N-1: set full[wr_bank], idx <= 0, toggle wr_bank.
REQ-018 out_valid = full[rd_bank]; out_a/out_b driven from bank rd_bank.
REQ-019 On drain: clear full[rd_bank], toggle rd_bank.
REQ-020 Latency: out_valid SHALL rise the cycle after the accept of the closing element.
REQ-021 Throughput: with out_ready held 1, one element per cycle sustained and in_ready never deasserts.
REQ-022 Simultaneous drain of one bank and completion of the other in the same cycle SHALL both take effect; no stall and no data loss.
REQ-023 out_a/out_b SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 No arithmetic is performed; elements pass through bit-exact.

Reset
REQ-025 While rst_n=0: idx=0, wr_bank=rd_bank=0, full flags 0, FSM in FILL, all bank storage 0; hence out_valid=0, in_ready=1, out_a/out_b all 0. A partially filled vector SHALL be discarded.

Configuration
REQ-026 With LOADER_ZERO_PAD_EN defined, an accepted element with in_last=1 at idx=k SHALL close the vector as in REQ-017, and lanes k+1..N-1 SHALL read 0. in_last at idx=N-1 SHALL behave as a normal close.
REQ-027 Without LOADER_ZERO_PAD_EN, in_last SHALL be ignored and vectors close only at idx=N-1.

Structure
REQ-028 The shared package kiwi_npu_pkg SHALL hold the fixed-point element typedef (signed WIDTH) and the fill-FSM state enum; WIDTH defaults come from fixed_point.vh.
REQ-029 A sub-module operand_bank (one N-lane a/b register bank with write-lane enable, zero-fill and full flag) SHALL be instantiated twice.

Verification (N=4, WIDTH=16)
REQ-030 Reset: rst_n low then high -> out_valid=0, in_ready=1, out_a/out_b all 0.
REQ-031 Streaming: out_ready=1, 8 back-to-back elements a=1..8, b=-1..-8 -> out_a={1,2,3,4}, out_b={-1,-2,-3,-4} valid the cycle after the 4th accept, then {5..8}/{-5..-8}; in_ready constantly 1.
REQ-032 Backpressure: out_ready=0, 9 elements offered -> in_ready=0 after the 8th accept, 9th held; out_ready=1 -> {1..4} drained, in_ready=1 next cycle, 9th accepted, then {5..8} presented.
REQ-033 Zero pad: macro defined, a=7,8,9 with in_last on 9 -> out_a={7,8,9,0}; macro undefined -> no out_valid until the 4th element.
REQ-034 Reset mid-fill: 2 elements accepted, rst_n pulsed low -> next 4 elements 10..13 form out_a={10,11,12,13}.

Source files
------------

// File: rtl/kiwi_npu_pkg.sv
// kiwi_npu_pkg: shared fixed-point element type and fill-FSM state encoding.
// FP_WIDTH supplies the default element width when no fixed-point header has set it.
`ifndef FP_WIDTH
`define FP_WIDTH 16
`endif

package kiwi_npu_pkg;
   localparam int FP_W = `FP_WIDTH;
   typedef logic signed [FP_W-1:0] fp_t;
   typedef enum logic {FILL = 1'b0, STALL = 1'b1} fill_state_e;
endpackage

// File: rtl/operand_bank.sv
// operand_bank: one N-lane a/b register bank with lane write, zero-fill above the
// written lane on an early close, and a full flag.
module operand_bank
   import kiwi_npu_pkg::*;
#(
   parameter int WIDTH = FP_W,
   parameter int N     = 4,
   parameter int IW    = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    we_i,
   input  logic                    pad_i,
   input  logic                    set_full_i,
   input  logic                    clr_full_i,
   input  logic [IW-1:0]           lane_i,
   input  logic signed [WIDTH-1:0] a_i,
   input  logic signed [WIDTH-1:0] b_i,
   output logic                    full_o,
   output logic signed [WIDTH-1:0] a_o [N],
   output logic signed [WIDTH-1:0] b_o [N]
);
   logic                    full_q;
   logic signed [WIDTH-1:0] a_q [N];
   logic signed [WIDTH-1:0] b_q [N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         for (int j = 0; j < N; j++) begin
            a_q[j] <= '0;
            b_q[j] <= '0;
         end
      end else begin
         if (set_full_i) full_q <= 1'b1;
         else if (clr_full_i) full_q <= 1'b0;
         for (int j = 0; j < N; j++) begin
            if (we_i && j == int'(lane_i)) begin
               a_q[j] <= a_i;
               b_q[j] <= b_i;
            end else if (we_i && pad_i && j > int'(lane_i)) begin
               a_q[j] <= '0;
               b_q[j] <= '0;
            end
         end
      end
   end

   assign full_o = full_q;
   assign a_o    = a_q;
   assign b_o    = b_q;
endmodule

// File: rtl/operand_loader.sv
// operand_loader: ping-pong loader assembling element pairs into N-lane a/b vectors.
// LOADER_ZERO_PAD_EN lets in_last close a vector early with zeroed upper lanes.
module operand_loader
   import kiwi_npu_pkg::*;
#(
   parameter int WIDTH = `FP_WIDTH,
   parameter int N     = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_a,
   input  logic signed [WIDTH-1:0] in_b,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_a [N],
   output logic signed [WIDTH-1:0] out_b [N]
);
   localparam int   IW       = $clog2(N);
   localparam logic ST_FILL  = 1'(FILL);
   localparam logic ST_STALL = 1'(STALL);

   logic [IW-1:0]           idx_q, idx_d;
   logic                    wr_q, wr_d, rd_q, rd_d, state_q, state_d;
   logic                    acc, close, drain, early;
   logic [1:0]              full;
   logic signed [WIDTH-1:0] ba [2][N];
   logic signed [WIDTH-1:0] bb [2][N];

`ifdef LOADER_ZERO_PAD_EN
   assign early = in_last;
`else
   logic unused_last;
   assign unused_last = in_last;
   assign early       = 1'b0;
`endif

   assign in_ready  = state_q == ST_FILL;
   assign acc       = in_valid && in_ready;
   assign close     = acc && (idx_q == IW'(N-1) || early);
   assign out_valid = full[rd_q];
   assign drain     = out_valid && out_ready;
   assign out_a     = ba[rd_q];
   assign out_b     = bb[rd_q];

   // a completion only stalls if the other bank stays full this cycle
   always_comb begin
      idx_d   = close ? '0 : acc ? idx_q + 1'b1 : idx_q;
      wr_d    = close ? ~wr_q : wr_q;
      rd_d    = drain ? ~rd_q : rd_q;
      state_d = (state_q == ST_STALL) ? (drain ? ST_FILL : ST_STALL)
              : (close && full[~wr_q] && !drain) ? ST_STALL : ST_FILL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         state_q <= ST_FILL;
      end else begin
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         state_q <= state_d;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      operand_bank #(.WIDTH(WIDTH), .N(N), .IW(IW)) u_bank (
         .clk       (clk),
         .rst_n     (rst_n),
         .we_i      (acc && wr_q == 1'(g)),
         .pad_i     (close),
         .set_full_i(close && wr_q == 1'(g)),
         .clr_full_i(drain && rd_q == 1'(g)),
         .lane_i    (idx_q),
         .a_i       (in_a),
         .b_i       (in_b),
         .full_o    (full[g]),
         .a_o       (ba[g]),
         .b_o       (bb[g])
      );
   end
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: scoreboard bench for operand_loader (N=4, WIDTH=16).
module tb_operand_loader;
   localparam int N = 4;
   localparam int W = 16;
`ifdef LOADER_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif
   typedef logic [2*N*W-1:0] vec_t;

   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid;
   logic signed [W-1:0] in_a = '0, in_b = '0;
   logic signed [W-1:0] out_a [N];
   logic signed [W-1:0] out_b [N];

   int checks = 0, errors = 0, drains = 0, exp_drains = 0, m_idx = 0;
   vec_t exp_q [$];
   logic signed [W-1:0] m_a [N];
   logic signed [W-1:0] m_b [N];
   logic done = 1'b0;

   always #5 clk = ~clk;

   operand_loader #(.WIDTH(W), .N(N)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_a    (out_a),
      .out_b    (out_b)
   );

   function automatic vec_t pack_out();
      vec_t v;
      for (int j = 0; j < N; j++) begin
         v[j*W +: W]     = out_a[j];
         v[(N+j)*W +: W] = out_b[j];
      end
      return v;
   endfunction

   function automatic vec_t vec_of(input int a0);
      vec_t v;
      for (int j = 0; j < N; j++) begin
         v[j*W +: W]     = W'(a0 + j);
         v[(N+j)*W +: W] = W'(-(a0 + j));
      end
      return v;
   endfunction

   task automatic model_clear();
      for (int j = 0; j < N; j++) begin
         m_a[j] = '0;
         m_b[j] = '0;
      end
      m_idx = 0;
   endtask

   task automatic model_accept(input int a, input int b, input logic last);
      vec_t v;
      m_a[m_idx] = W'(a);
      m_b[m_idx] = W'(b);
      if (m_idx == N-1 || (PAD && last)) begin
         for (int j = 0; j < N; j++) begin
            v[j*W +: W]     = m_a[j];
            v[(N+j)*W +: W] = m_b[j];
         end
         exp_q.push_back(v);
         exp_drains++;
         model_clear();
      end else m_idx++;
   endtask

   always @(negedge clk) begin
      vec_t e;
      if (rst_n && out_valid && out_ready) begin
         drains++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL drain_unexpected: got %h want no vector", pack_out());
         end else begin
            e = exp_q.pop_front();
            if (pack_out() !== e) begin
               errors++;
               $display("FAIL drain_data: got %h want %h", pack_out(), e);
            end
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_last = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      model_clear();
      exp_q.delete();
      exp_drains = drains;
      #1 rst_n = 1'b1;
   endtask

   task automatic send(input int a, input int b, input logic last, output logic r0, output logic ov0);
      logic ok;
      int t;
      in_valid = 1'b1;
      in_a = W'(a);
      in_b = W'(b);
      in_last = last;
      ok = 1'b0;
      t = 0;
      r0 = 1'b0;
      ov0 = 1'b0;
      while (!ok && t < 100) begin
         @(negedge clk);
         if (t == 0) begin
            r0 = in_ready;
            ov0 = out_valid;
         end
         ok = in_ready;
         @(posedge clk);
         t++;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_timeout: got in_ready=0 for %0d cycles want 1", t);
      end else model_accept(a, b, last);
      #1 in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++;
      if (pack_out() !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", pack_out()); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_streaming();
      logic r, ov;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(i + 1, -(i + 1), 1'b0, r, ov);
         checks++;
         if (r !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, r); end
         if (i == 3 || i == 4) begin
            checks++;
            if (ov !== (i == 4)) begin errors++; $display("FAIL stream_latency[%0d]: got %b want %b", i, ov, i == 4); end
         end
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_second_valid: got %b want 1", out_valid); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      logic r, ov;
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(i + 1, -(i + 1), 1'b0, r, ov);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: got in_ready=%b want 0", in_ready); end
      checks++;
      if (pack_out() !== vec_of(1)) begin errors++; $display("FAIL bp_first: got %h want %h", pack_out(), vec_of(1)); end
      in_valid = 1'b1;
      in_a = 16'sd9;
      in_b = -16'sd9;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_held: got in_ready=%b want 0", in_ready); end
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume: got in_ready=%b want 1", in_ready); end
      checks++;
      if (out_valid !== 1'b1 || pack_out() !== vec_of(5)) begin
         errors++;
         $display("FAIL bp_second: got v=%b %h want v=1 %h", out_valid, pack_out(), vec_of(5));
      end
      @(posedge clk);
      model_accept(9, -9, 1'b0);
      #1 in_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || pack_out() !== vec_of(5)) begin
            errors++;
            $display("FAIL bp_stable: got v=%b %h want v=1 %h", out_valid, pack_out(), vec_of(5));
         end
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset_midfill();
      logic r, ov;
      do_reset();
      out_ready = 1'b1;
      send(100, -100, 1'b0, r, ov);
      send(101, -101, 1'b0, r, ov);
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(10 + i, -(10 + i), 1'b0, r, ov);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || pack_out() !== vec_of(10)) begin
         errors++;
         $display("FAIL midfill: got v=%b %h want v=1 %h", out_valid, pack_out(), vec_of(10));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      logic r, ov;
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 7; i++) send(20 + i, -(20 + i), 1'b0, r, ov);
      out_ready = 1'b1;
      send(27, -27, 1'b0, r, ov);
      checks++;
      if (r !== 1'b1 || ov !== 1'b1) begin errors++; $display("FAIL b2b_pre: got r=%b v=%b want 1 1", r, ov); end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_no_stall: got in_ready=%b want 1", in_ready); end
      checks++;
      if (out_valid !== 1'b1 || pack_out() !== vec_of(24)) begin
         errors++;
         $display("FAIL b2b_second: got v=%b %h want v=1 %h", out_valid, pack_out(), vec_of(24));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_zero_pad();
      logic r, ov;
      out_ready = 1'b1;
      send(7, -7, 1'b0, r, ov);
      send(8, -8, 1'b0, r, ov);
      send(9, -9, 1'b1, r, ov);
      @(negedge clk);
      checks++;
      if (out_valid !== PAD) begin errors++; $display("FAIL pad_early_close: got %b want %b", out_valid, PAD); end
      @(posedge clk);
      #1;
      send(10, -10, 1'b0, r, ov);
      @(negedge clk);
      checks++;
      if (out_valid !== !PAD) begin errors++; $display("FAIL pad_fourth: got %b want %b", out_valid, !PAD); end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) send(11 + i, -(11 + i), 1'b0, r, ov);
   endtask

   task automatic test_random();
      logic r, ov;
      int a;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               a = int'($urandom_range(0, 65535)) - 32768;
               send(a, int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 3) == 0, r, ov);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 out_ready = $urandom_range(0, 1) == 1;
            end
         end
      join
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
   endtask

   initial begin
      model_clear();
      test_reset();
      test_streaming();
      test_backpressure();
      test_reset_midfill();
      test_back_to_back();
      test_zero_pad();
      test_random();
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL pending_vectors: got %0d left want 0", exp_q.size()); end
      checks++;
      if (drains != exp_drains) begin errors++; $display("FAIL drain_count: got %0d want %0d", drains, exp_drains); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
